// File: rtl/frl_ckpt_ctrl_pkg.sv
// Shared sizing and types for the FRL branch-checkpoint controller.
// FRL is a 16-entry FIFO; pointers carry one extra wrap bit.
package frl_ckpt_ctrl_pkg;

  localparam int FRL_DEPTH   = 16;
  localparam int FRL_PTR_W   = 5;
  localparam int NUM_BR_CKPT = 4;
  localparam int BR_TAG_W    = 2;

  typedef logic [BR_TAG_W-1:0]  br_tag_t;
  typedef logic [FRL_PTR_W-1:0] frl_ptr_t;

  // Restore sequencer: IDLE, or driving the one-cycle pointer restore/flush.
  typedef enum logic {
    RS_IDLE    = 1'b0,
    RS_RESTORE = 1'b1
  } restore_state_e;

endpackage

// File: rtl/frl_ckpt_ctrl_prio_enc_lsb.sv
// Lowest-set-bit priority encoder: one-hot and binary index of the first
// requesting bit, plus an any-request flag.
module frl_ckpt_ctrl_prio_enc_lsb #(
  parameter int W     = 4,
  parameter int IDX_W = 2
) (
  input  logic [W-1:0]     req_i,
  output logic [W-1:0]     gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             any_o
);

  // Scanning from the top down lets the lowest requester be the last write.
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    any_o     = |req_i;
    for (int i = W - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_oh_o    = '0;
        gnt_oh_o[i] = 1'b1;
        gnt_idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/frl_ckpt_ctrl.sv
// Branch-checkpoint controller for the FRL read side: snapshots the read
// pointer per branch and restores it plus a kill mask on mispredict.
module frl_ckpt_ctrl
  import frl_ckpt_ctrl_pkg::*;
#(
  parameter int NUM_CKPT = NUM_BR_CKPT,
  parameter int TAG_W    = BR_TAG_W,
  parameter int PTR_W    = FRL_PTR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                br_disp_valid,
  output logic                br_disp_ready,
  output logic [TAG_W-1:0]    br_disp_tag,
  input  logic [PTR_W-1:0]    frl_r_ptr,
  input  logic                br_res_valid,
  input  logic [TAG_W-1:0]    br_res_tag,
  input  logic                br_res_mispred,
  output logic                frl_chg_r_ptr_en,
  output logic [PTR_W-1:0]    frl_chg_r_ptr_val,
  output logic                flush_valid,
  output logic [NUM_CKPT-1:0] flush_mask,
  output logic [NUM_CKPT-1:0] ckpt_valid,
  output logic                disp_stall
);

  logic [NUM_CKPT-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]    ptr_q   [NUM_CKPT];
  logic [NUM_CKPT-1:0] older_q [NUM_CKPT];
  logic [NUM_CKPT-1:0] older_d [NUM_CKPT];

  restore_state_e      state_q;
  logic [PTR_W-1:0]    chg_val_q;
  logic [NUM_CKPT-1:0] flush_mask_q;

  logic [NUM_CKPT-1:0] free;
  logic [NUM_CKPT-1:0] alloc_oh;
  logic [TAG_W-1:0]    alloc_idx;
  logic                any_free;

  logic                res_hit, ok_hit, mis_hit, mis_any, restoring, fire;
  logic [NUM_CKPT-1:0] res_oh, kill, clr_mask;

  // Free is taken from the pre-update valid, so a slot released this cycle
  // only becomes grantable next cycle.
  assign free = ~valid_q;

  frl_ckpt_ctrl_prio_enc_lsb #(
    .W     (NUM_CKPT),
    .IDX_W (TAG_W)
  ) u_grant (
    .req_i     (free),
    .gnt_oh_o  (alloc_oh),
    .gnt_idx_o (alloc_idx),
    .any_o     (any_free)
  );

  assign restoring = (state_q == RS_RESTORE);
  assign res_hit   = br_res_valid && valid_q[br_res_tag];
  assign ok_hit    = res_hit && !br_res_mispred;
  assign mis_hit   = res_hit && br_res_mispred;
  assign mis_any   = br_res_valid && br_res_mispred;

  // Dispatch handshake: a branch is allocated exactly on a cycle where
  // br_disp_valid && br_disp_ready; br_disp_tag is the granted tag then and
  // meaningless otherwise. Ready does not depend on valid.
  assign br_disp_ready = any_free && !mis_any && !restoring;
  assign br_disp_tag   = alloc_idx;
  assign fire          = br_disp_valid && br_disp_ready;

  // Kill = mispredicted slot plus every live slot that saw it as older.
  always_comb begin
    res_oh             = '0;
    res_oh[br_res_tag] = 1'b1;
    kill               = res_oh;
    for (int j = 0; j < NUM_CKPT; j++) begin
      if (valid_q[j] && older_q[j][br_res_tag]) kill[j] = 1'b1;
    end
    clr_mask = '0;
    if (mis_hit)     clr_mask = kill;
    else if (ok_hit) clr_mask = res_oh;
  end

  always_comb begin
    valid_d = (valid_q & ~clr_mask) | (fire ? alloc_oh : '0);
    for (int j = 0; j < NUM_CKPT; j++) begin
      if (fire && alloc_oh[j]) older_d[j] = valid_q & ~clr_mask;
      else                     older_d[j] = older_q[j] & ~clr_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= '0;
      state_q      <= RS_IDLE;
      chg_val_q    <= '0;
      flush_mask_q <= '0;
      for (int j = 0; j < NUM_CKPT; j++) begin
        ptr_q[j]   <= '0;
        older_q[j] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int j = 0; j < NUM_CKPT; j++) older_q[j] <= older_d[j];
      if (fire) ptr_q[alloc_idx] <= frl_r_ptr;

      // A mispredict arriving during a restore simply re-arms the restore.
      case (state_q)
        RS_IDLE, RS_RESTORE: begin
          if (mis_hit) begin
            state_q      <= RS_RESTORE;
            chg_val_q    <= ptr_q[br_res_tag];
            flush_mask_q <= kill;
          end else begin
            state_q      <= RS_IDLE;
            chg_val_q    <= '0;
            flush_mask_q <= '0;
          end
        end
        default: begin
          state_q      <= RS_IDLE;
          chg_val_q    <= '0;
          flush_mask_q <= '0;
        end
      endcase
    end
  end

  assign frl_chg_r_ptr_en  = restoring;
  assign frl_chg_r_ptr_val = chg_val_q;
  assign flush_valid       = restoring;
  assign flush_mask        = flush_mask_q;
  assign ckpt_valid        = valid_q;
  // Stall on the wrong-path cycle and on the restore cycle, where the FRL
  // prioritises the pointer change over a pop.
  assign disp_stall        = mis_hit || restoring;

endmodule

// File: tb/tb_frl_ckpt_ctrl.sv
// Bench for frl_ckpt_ctrl: directed scenarios plus random traffic, checked
// against an in-order list model of live branches.
module tb_frl_ckpt_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       br_disp_valid;
  logic       br_disp_ready;
  logic [1:0] br_disp_tag;
  logic [4:0] frl_r_ptr;
  logic       br_res_valid;
  logic [1:0] br_res_tag;
  logic       br_res_mispred;
  logic       frl_chg_r_ptr_en;
  logic [4:0] frl_chg_r_ptr_val;
  logic       flush_valid;
  logic [3:0] flush_mask;
  logic [3:0] ckpt_valid;
  logic       disp_stall;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  frl_ckpt_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .br_disp_valid     (br_disp_valid),
    .br_disp_ready     (br_disp_ready),
    .br_disp_tag       (br_disp_tag),
    .frl_r_ptr         (frl_r_ptr),
    .br_res_valid      (br_res_valid),
    .br_res_tag        (br_res_tag),
    .br_res_mispred    (br_res_mispred),
    .frl_chg_r_ptr_en  (frl_chg_r_ptr_en),
    .frl_chg_r_ptr_val (frl_chg_r_ptr_val),
    .flush_valid       (flush_valid),
    .flush_mask        (flush_mask),
    .ckpt_valid        (ckpt_valid),
    .disp_stall        (disp_stall)
  );

  // ---------------- scoreboard / model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  // Live branches in program order, oldest first; each entry is its tag.
  int         order_q[$];
  logic [4:0] m_ptr[4];
  logic       m_chg_en;
  logic [4:0] m_chg_val;
  logic [3:0] m_mask;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] live_map();
    logic [3:0] m;
    m = '0;
    foreach (order_q[p]) m[order_q[p]] = 1'b1;
    return m;
  endfunction

  task automatic model_clear();
    order_q.delete();
    for (int i = 0; i < 4; i++) m_ptr[i] = '0;
    m_chg_en  = 1'b0;
    m_chg_val = '0;
    m_mask    = '0;
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle(input logic rst, input logic dv, input logic [4:0] rp,
                       input logic rv, input logic [1:0] rt, input logic rm);
    logic [3:0] live;
    logic       hit, exp_ready, fire;
    int         exp_tag, pos;
    @(negedge clk);
    reset          = rst;
    br_disp_valid  = dv;
    frl_r_ptr      = rp;
    br_res_valid   = rv;
    br_res_tag     = rt;
    br_res_mispred = rm;
    #1;
    live      = live_map();
    hit       = rv && live[rt];
    exp_ready = (live != 4'hF) && !(rv && rm) && !m_chg_en;
    exp_tag   = 0;
    for (int i = 3; i >= 0; i--) if (!live[i]) exp_tag = i;

    check_eq("ckpt_valid", ckpt_valid, live);
    check_eq("br_disp_ready", br_disp_ready, exp_ready);
    check_eq("disp_stall", disp_stall, (hit && rm) || m_chg_en);
    check_eq("chg_en", frl_chg_r_ptr_en, m_chg_en);
    check_eq("chg_val", frl_chg_r_ptr_val, m_chg_val);
    check_eq("flush_valid", flush_valid, m_chg_en);
    check_eq("flush_mask", flush_mask, m_mask);
    if (dv && exp_ready) check_eq("disp_tag", br_disp_tag, exp_tag);
    fire = dv && exp_ready;

    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      m_chg_en  = hit && rm;
      m_chg_val = '0;
      m_mask    = '0;
      if (hit) begin
        pos = 0;
        foreach (order_q[p]) if (order_q[p] == int'(rt)) pos = p;
        if (rm) begin
          m_chg_val = m_ptr[rt];
          for (int p = pos; p < order_q.size(); p++) m_mask[order_q[p]] = 1'b1;
          while (order_q.size() > pos) void'(order_q.pop_back());
        end else begin
          order_q.delete(pos);
        end
      end
      if (fire) begin
        order_q.push_back(exp_tag);
        m_ptr[exp_tag] = rp;
      end
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    cycle(1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic disp(input logic [4:0] rp);
    cycle(1'b0, 1'b1, rp, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic resolve(input logic [1:0] rt, input logic rm);
    cycle(1'b0, 1'b0, 5'd0, 1'b1, rt, rm);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; br_disp_valid = 1'b0; frl_r_ptr = '0;
    br_res_valid = 1'b0; br_res_tag = '0; br_res_mispred = 1'b0;
    model_clear();

    // Reset state
    do_reset();
    #2;
    check_eq("rst_ckpt_valid", ckpt_valid, 4'h0);
    check_eq("rst_ready", br_disp_ready, 1'b1);
    check_eq("rst_flush", flush_valid, 1'b0);

    // Fill all four slots, then a fifth request is refused
    disp(5'd0); disp(5'd2); disp(5'd5); disp(5'd9);
    #2;
    check_eq("full_ckpt_valid", ckpt_valid, 4'hF);
    disp(5'd11);
    #2;
    check_eq("full_no_grant", ckpt_valid, 4'hF);

    // Mispredict tag 1 kills 1,2,3 and restores pointer 2
    resolve(2'd1, 1'b1);
    #2;
    check_eq("mp1_chg_en", frl_chg_r_ptr_en, 1'b1);
    check_eq("mp1_chg_val", frl_chg_r_ptr_val, 5'd2);
    check_eq("mp1_mask", flush_mask, 4'b1110);
    check_eq("mp1_ckpt", ckpt_valid, 4'b0001);
    idle();
    #2;
    check_eq("mp1_one_cycle", flush_valid, 1'b0);

    // Correct resolve of tag 2, then mispredict tag 1 kills only 1 and 3
    do_reset();
    disp(5'd0); disp(5'd2); disp(5'd5); disp(5'd9);
    resolve(2'd2, 1'b0);
    #2;
    check_eq("ok2_ckpt", ckpt_valid, 4'b1011);
    check_eq("ok2_no_flush", flush_valid, 1'b0);
    resolve(2'd1, 1'b1);
    #2;
    check_eq("mp1b_mask", flush_mask, 4'b1010);
    idle();

    // Dispatch collides with mispredict of tag 0: no grant, two stall cycles
    do_reset();
    disp(5'd3);
    cycle(1'b0, 1'b1, 5'd4, 1'b1, 2'd0, 1'b1);
    #2;
    check_eq("coll_stall2", disp_stall, 1'b1);
    check_eq("coll_ckpt", ckpt_valid, 4'h0);
    idle();

    // Mispredict of a dead tag is ignored
    do_reset();
    disp(5'd1); disp(5'd2);
    resolve(2'd3, 1'b1);
    #2;
    check_eq("dead_no_flush", flush_valid, 1'b0);
    check_eq("dead_no_chg", frl_chg_r_ptr_en, 1'b0);
    check_eq("dead_ckpt", ckpt_valid, 4'b0011);
    idle();

    // Wrap bit restored intact, then reset during the restore cycle
    do_reset();
    disp(5'd0); disp(5'd2); disp(5'b10011);
    resolve(2'd2, 1'b1);
    #2;
    check_eq("wrap_chg_val", frl_chg_r_ptr_val, 5'b10011);
    cycle(1'b1, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    #2;
    check_eq("rst_mid_chg_en", frl_chg_r_ptr_en, 1'b0);
    check_eq("rst_mid_flush", flush_valid, 1'b0);
    check_eq("rst_mid_ckpt", ckpt_valid, 4'h0);
    idle();

    // Back-to-back mispredicts: tag 2 then older tag 0 in the restore cycle
    do_reset();
    disp(5'd7); disp(5'd8); disp(5'd12); disp(5'd14);
    resolve(2'd2, 1'b1);
    resolve(2'd0, 1'b1);
    #2;
    check_eq("b2b_chg_val", frl_chg_r_ptr_val, 5'd7);
    check_eq("b2b_mask", flush_mask, 4'b0011);
    check_eq("b2b_ckpt", ckpt_valid, 4'h0);
    idle();

    // Random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 149) == 0),
            ($urandom_range(0, 9) < 6),
            5'($urandom),
            ($urandom_range(0, 9) < 4),
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 9) < 3));
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
